// File: rtl/instruction_encoder_if.sv
// Request/memory-write bundle for instruction_encoder.
// The master drives requests and memory status; the slave is the encoder.
interface instruction_encoder_if #(
  parameter int DEPTH = 4
);
  logic                    Valid;
  logic                    Ready;
  logic [3:0]              Mnemonic;
  logic [4:0]              Rs;
  logic [4:0]              Rt;
  logic [4:0]              Rd;
  logic [4:0]              Shamt;
  logic [25:0]             Imm;
  logic                    Flush;
  logic                    MemStall;
  logic                    MemWrite;
  logic [31:0]             MemAddress;
  logic [31:0]             MemData;
  logic                    Illegal;
  logic [$clog2(DEPTH):0]  Count;

  modport master (
    output Valid, Mnemonic, Rs, Rt, Rd, Shamt, Imm, Flush, MemStall,
    input  Ready, MemWrite, MemAddress, MemData, Illegal, Count
  );

  modport slave (
    input  Valid, Mnemonic, Rs, Rt, Rd, Shamt, Imm, Flush, MemStall,
    output Ready, MemWrite, MemAddress, MemData, Illegal, Count
  );
endinterface

// File: rtl/instruction_encoder.sv
// Encodes mnemonic requests into MIPS words, queues them in a small FIFO and
// writes them to sequential instruction-memory addresses.
module instruction_encoder #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0040_0000,
  parameter int          MEM_WORDS = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  instruction_encoder_if.slave bus
);
  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * (MEM_WORDS - 1));

  logic [31:0]   r_fifo [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_mem_write;
  logic [31:0]   r_mem_addr;
  logic [31:0]   r_mem_data;
  logic          r_illegal;

  logic [31:0]   w_word;
  logic          w_legal;
  logic          w_full;
  logic          w_accept;
  logic          w_push;
  logic          w_out_free;
  logic          w_done;
  logic          w_bypass;
  logic          w_fifo_wr;
  logic          w_fifo_pop;
  logic          w_load;

  always_comb begin
    w_word  = '0;
    w_legal = 1'b1;
    case (bus.Mnemonic)
      4'd0:  w_word = {6'h00, bus.Rs, bus.Rt, bus.Rd, bus.Shamt, 6'h20};
      4'd1:  w_word = {6'h00, bus.Rs, bus.Rt, bus.Rd, bus.Shamt, 6'h22};
      4'd2:  w_word = {6'h00, bus.Rs, bus.Rt, bus.Rd, bus.Shamt, 6'h24};
      4'd3:  w_word = {6'h00, bus.Rs, bus.Rt, bus.Rd, bus.Shamt, 6'h25};
      4'd4:  w_word = {6'h00, bus.Rs, bus.Rt, bus.Rd, bus.Shamt, 6'h27};
      4'd5:  w_word = {6'h00, 5'd0, bus.Rt, bus.Rd, bus.Shamt, 6'h00};
      4'd6:  w_word = {6'h00, 5'd0, bus.Rt, bus.Rd, bus.Shamt, 6'h02};
      4'd7:  w_word = {6'h00, bus.Rs, 15'd0, 6'h08};
      4'd8:  w_word = {6'h08, bus.Rs, bus.Rt, bus.Imm[15:0]};
      4'd9:  w_word = {6'h0D, bus.Rs, bus.Rt, bus.Imm[15:0]};
      4'd10: w_word = {6'h0F, 5'd0, bus.Rt, bus.Imm[15:0]};
      4'd11: w_word = {6'h04, bus.Rs, bus.Rt, bus.Imm[15:0]};
      4'd12: w_word = {6'h05, bus.Rs, bus.Rt, bus.Imm[15:0]};
      4'd13: w_word = {6'h02, bus.Imm};
      4'd14: w_word = {6'h03, bus.Imm};
      default: w_legal = 1'b0;
    endcase
  end

  assign w_full     = (r_count == (AW+1)'(DEPTH));
  assign w_accept   = bus.Valid & ~w_full & ~bus.Flush;
  assign w_push     = w_accept & w_legal;
  assign w_out_free = ~r_mem_write | ~bus.MemStall;
  assign w_done     = r_mem_write & ~bus.MemStall;
  // An empty queue lets a fresh word go straight to the output stage.
  assign w_bypass   = w_push & w_out_free & (r_count == '0);
  assign w_fifo_wr  = w_push & ~w_bypass;
  assign w_fifo_pop = w_out_free & (r_count != '0);
  assign w_load     = w_bypass | w_fifo_pop;

  always_ff @(posedge clk) begin
    if (w_fifo_wr && !bus.Flush) r_fifo[r_wr_ptr] <= w_word;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (bus.Flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_fifo_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_fifo_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_fifo_wr, w_fifo_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem_write <= 1'b0;
      r_mem_addr  <= BASE_ADDR;
      r_mem_data  <= '0;
      r_illegal   <= 1'b0;
    end else begin
      r_illegal <= w_accept & ~w_legal;
      if (bus.Flush) begin
        r_mem_write <= 1'b0;
        r_mem_addr  <= BASE_ADDR;
      end else begin
        if (w_done) r_mem_addr <= (r_mem_addr == LAST_ADDR) ? BASE_ADDR : r_mem_addr + 32'd4;
        if (w_out_free) begin
          r_mem_write <= w_load;
          if (w_load) r_mem_data <= w_fifo_pop ? r_fifo[r_rd_ptr] : w_word;
        end
      end
    end
  end

  assign bus.Ready      = ~w_full;
  assign bus.MemWrite   = r_mem_write;
  assign bus.MemAddress = r_mem_addr;
  assign bus.MemData    = r_mem_data;
  assign bus.Illegal    = r_illegal;
  assign bus.Count      = r_count;
endmodule

// File: tb/tb_instruction_encoder.sv
// Self-checking bench for instruction_encoder: vector table, scoreboard of
// expected words/addresses, and hand sequences for stall, flush, reset and wrap.
module tb_instruction_encoder;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0040_0000;
  localparam int          MW    = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instruction_encoder_if #(.DEPTH(DEPTH)) bus ();
  instruction_encoder_if #(.DEPTH(DEPTH)) bus2 ();

  instruction_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .MEM_WORDS(MW)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave));
  instruction_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .MEM_WORDS(4)) dut_wrap (
    .clk(clk), .reset(reset), .bus(bus2.slave));

  typedef struct {
    logic [3:0]  mn;
    logic [31:0] word;
  } vec_t;

  vec_t        tbl [15];
  logic [31:0] sb [$];
  logic [31:0] cur_exp;
  logic [31:0] exp_addr;
  logic        ill_pend;
  int          total = 0;
  int          bad = 0;
  int          n_writes = 0;
  int          n_ill = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: push on acceptance, pop/compare on each completed write.
  always @(negedge clk) begin
    if (!reset) begin
      sb.delete();
      exp_addr = BASE;
      ill_pend = 1'b0;
    end else begin
      if (ill_pend || bus.Illegal) check("illegal_pulse", 32'(bus.Illegal), 32'(ill_pend));
      if (bus.Illegal) n_ill++;
      if (bus.MemWrite && !bus.MemStall) begin
        n_writes++;
        if (sb.size() == 0) check("write_without_request", 32'(bus.MemWrite), 32'd0);
        else begin
          check("mem_data", bus.MemData, sb.pop_front());
          check("mem_addr", bus.MemAddress, exp_addr);
        end
        exp_addr = (exp_addr == BASE + 32'(4 * (MW - 1))) ? BASE : exp_addr + 32'd4;
      end
      if (bus.Flush) begin
        sb.delete();
        exp_addr = BASE;
      end
      ill_pend = bus.Valid && bus.Ready && !bus.Flush && (bus.Mnemonic == 4'd15);
      if (bus.Valid && bus.Ready && !bus.Flush && bus.Mnemonic != 4'd15) sb.push_back(cur_exp);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] mn, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [25:0] imm,
                      input logic [31:0] exp);
    int n = 0;
    bus.Mnemonic = mn; bus.Rs = rs; bus.Rt = rt; bus.Rd = rd; bus.Shamt = sh; bus.Imm = imm;
    cur_exp = exp;
    bus.Valid = 1'b1;
    @(negedge clk);
    while (!bus.Ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("send_timeout", 32'(bus.Ready), 32'd1);
    tick();
    bus.Valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || bus.MemWrite) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int w0;
    int i0;
    logic [31:0] wrap_addr [5];

    tbl[0]  = '{4'd0,  32'h0022_1920};
    tbl[1]  = '{4'd1,  32'h0022_1922};
    tbl[2]  = '{4'd2,  32'h0022_1924};
    tbl[3]  = '{4'd3,  32'h0022_1925};
    tbl[4]  = '{4'd4,  32'h0022_1927};
    tbl[5]  = '{4'd5,  32'h0002_1900};
    tbl[6]  = '{4'd6,  32'h0002_1902};
    tbl[7]  = '{4'd7,  32'h0020_0008};
    tbl[8]  = '{4'd8,  32'h2022_FFFF};
    tbl[9]  = '{4'd9,  32'h3422_FFFF};
    tbl[10] = '{4'd10, 32'h3C02_FFFF};
    tbl[11] = '{4'd11, 32'h1022_FFFF};
    tbl[12] = '{4'd12, 32'h1422_FFFF};
    tbl[13] = '{4'd13, 32'h0BFF_FFFF};
    tbl[14] = '{4'd14, 32'h0FFF_FFFF};
    wrap_addr[0] = BASE; wrap_addr[1] = BASE + 32'd4; wrap_addr[2] = BASE + 32'd8;
    wrap_addr[3] = BASE + 32'd12; wrap_addr[4] = BASE;

    bus.Valid = 0; bus.Mnemonic = 0; bus.Rs = 0; bus.Rt = 0; bus.Rd = 0; bus.Shamt = 0;
    bus.Imm = 0; bus.Flush = 0; bus.MemStall = 0;
    bus2.Valid = 0; bus2.Mnemonic = 4'd8; bus2.Rs = 0; bus2.Rt = 5'd8; bus2.Rd = 0;
    bus2.Shamt = 0; bus2.Imm = 0; bus2.Flush = 0; bus2.MemStall = 0;
    cur_exp = 0;
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    check("rst_mem_write", 32'(bus.MemWrite), 32'd0);
    check("rst_mem_addr", bus.MemAddress, BASE);
    check("rst_mem_data", bus.MemData, 32'd0);
    check("rst_illegal", 32'(bus.Illegal), 32'd0);
    check("rst_count", 32'(bus.Count), 32'd0);
    check("rst_ready", 32'(bus.Ready), 32'd1);

    // Single ADDI: written the very next cycle.
    send(4'd8, 5'd0, 5'd8, 5'd0, 5'd0, 26'h0005, 32'h2008_0005);
    check("addi_latency", 32'(bus.MemWrite), 32'd1);
    check("addi_word", bus.MemData, 32'h2008_0005);
    check("addi_addr", bus.MemAddress, BASE);
    drain();

    for (int i = 0; i < 15; i++)
      send(tbl[i].mn, 5'd1, 5'd2, 5'd3, 5'd4, 26'h3FF_FFFF, tbl[i].word);
    drain();
    check("stream_writes", 32'(n_writes), 32'd16);

    // Stall: output stage plus DEPTH entries fill before Ready drops.
    bus.MemStall = 1'b1;
    for (int k = 0; k < DEPTH + 1; k++)
      send(4'd8, 5'd0, 5'd8, 5'd0, 5'd0, 26'(16'h0100 + k), 32'h2008_0100 + 32'(k));
    check("stall_ready", 32'(bus.Ready), 32'd0);
    check("stall_count", 32'(bus.Count), 32'(DEPTH));
    repeat (3) tick();
    check("stall_hold_write", 32'(bus.MemWrite), 32'd1);
    check("stall_hold_data", bus.MemData, 32'h2008_0100);
    check("stall_hold_addr", bus.MemAddress, BASE + 32'd64);
    check("stall_hold_count", 32'(bus.Count), 32'(DEPTH));
    bus.MemStall = 1'b0;
    send(4'd8, 5'd0, 5'd8, 5'd0, 5'd0, 26'h0105, 32'h2008_0105);
    drain();
    check("stall_writes", 32'(n_writes), 32'd22);

    // Illegal code between two ADDs.
    w0 = n_writes; i0 = n_ill;
    send(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 26'd0, 32'h0022_1820);
    send(4'd15, 5'd1, 5'd2, 5'd3, 5'd0, 26'd0, 32'hDEAD_BEEF);
    send(4'd0, 5'd4, 5'd5, 5'd6, 5'd0, 26'd0, 32'h0085_3020);
    drain();
    tick();
    check("illegal_writes", 32'(n_writes - w0), 32'd2);
    check("illegal_pulses", 32'(n_ill - i0), 32'd1);

    // Wrap on a 4-word memory.
    bus2.Valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus2.Imm = 26'(k);
      tick();
      if (k == 4) bus2.Valid = 1'b0;
      check("wrap_write", 32'(bus2.MemWrite), 32'd1);
      check("wrap_addr", bus2.MemAddress, wrap_addr[k]);
      check("wrap_data", bus2.MemData, 32'h2008_0000 + 32'(k));
    end
    tick();
    check("wrap_idle", 32'(bus2.MemWrite), 32'd0);

    // Flush with three words queued; the request presented with it is dropped.
    bus.MemStall = 1'b1;
    for (int k = 0; k < 4; k++)
      send(4'd8, 5'd0, 5'd8, 5'd0, 5'd0, 26'(16'h0200 + k), 32'h2008_0200 + 32'(k));
    check("flush_pre_count", 32'(bus.Count), 32'd3);
    w0 = n_writes;
    bus.Mnemonic = 4'd8; bus.Imm = 26'h0299; cur_exp = 32'h2008_0299;
    bus.Valid = 1'b1; bus.Flush = 1'b1;
    tick();
    bus.Valid = 1'b0; bus.Flush = 1'b0; bus.MemStall = 1'b0;
    check("flush_count", 32'(bus.Count), 32'd0);
    check("flush_mem_write", 32'(bus.MemWrite), 32'd0);
    repeat (3) tick();
    check("flush_no_writes", 32'(n_writes - w0), 32'd0);
    send(4'd8, 5'd0, 5'd8, 5'd0, 5'd0, 26'h0300, 32'h2008_0300);
    check("flush_next_addr", bus.MemAddress, BASE);
    check("flush_next_write", 32'(bus.MemWrite), 32'd1);
    drain();

    // Asynchronous reset mid-stall.
    bus.MemStall = 1'b1;
    for (int k = 0; k < 4; k++)
      send(4'd8, 5'd0, 5'd8, 5'd0, 5'd0, 26'(16'h0400 + k), 32'h2008_0400 + 32'(k));
    check("reset_pre_count", 32'(bus.Count), 32'd3);
    #2 reset = 1'b0;
    #1;
    check("areset_mem_write", 32'(bus.MemWrite), 32'd0);
    check("areset_count", 32'(bus.Count), 32'd0);
    check("areset_addr", bus.MemAddress, BASE);
    tick();
    reset = 1'b1;
    bus.MemStall = 1'b0;
    send(4'd8, 5'd0, 5'd8, 5'd0, 5'd0, 26'h0500, 32'h2008_0500);
    check("reset_next_addr", bus.MemAddress, BASE);
    check("reset_next_data", bus.MemData, 32'h2008_0500);
    drain();
    tick();
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
